bip_control_unit: RTL and testbench
===================================

Name: bip_control_unit

Overview:
- Multi-cycle control unit for the BIP datapath.
- Sequences instruction fetch from program memory, decodes the 5-bit opcode, and drives the datapath select lines: the 16-bit accumulator-input mux and the ALU-operand mux2 select.
- Also drives accumulator write enable, ALU op, and data-RAM read/write strobes.
- Owns the program counter; sits between program memory, data memory and the datapath.

Parameters:
- PC_W, 11, program counter / operand width.
- OPC_W, 5, opcode width.
- INSTR_W, 16, instruction width; must equal OPC_W + PC_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled in IDLE or HALT to begin execution at PC 0.
- instr  input  INSTR_W  program-memory read data; valid the cycle after pc_addr is presented (registered ROM).
- pc_addr  output  PC_W  program-memory address.
- operand  output  PC_W  instr[PC_W-1:0]; data-RAM address or immediate.
- sel_a  output  2  accumulator-input mux: 00 RAM data, 01 immediate, 10 ALU result.
- sel_b  output  1  ALU B-operand mux2 select: 1 immediate, 0 RAM data.
- op  output  1  ALU operation: 0 add, 1 subtract.
- wr_acc  output  1  accumulator write enable.
- rd_ram  output  1  data-RAM read strobe.
- wr_ram  output  1  data-RAM write strobe (stores accumulator).
- busy  output  1  high in FETCH, DECODE, EXEC.
- halted  output  1  high in HALT.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Reset (asynchronous, immediate, valid mid-instruction):
  - state=IDLE, pc=0, IR=0.
  - All outputs 0, including sel_a=00, busy=0, halted=0.
- IDLE: start=1 → FETCH with pc=0; otherwise stay.
- FETCH: pc_addr=pc. Always → DECODE.
- DECODE:
  - instr is valid; latch it into IR.
  - operand driven from instr this cycle.
  - rd_ram=1 if opcode ∈ {LD, ADD, SUB}, so RAM data is ready in EXEC.
  - Always → EXEC.
- EXEC: controls decoded from IR, each asserted exactly one cycle:
  - HLT 00000: no strobes; pc held; → HALT.
  - STO 00001: wr_ram=1.
  - LD 00010: sel_a=00, wr_acc=1.
  - LDI 00011: sel_a=01, wr_acc=1.
  - ADD 00100: sel_a=10, sel_b=0, op=0, wr_acc=1.
  - ADDI 00101: sel_a=10, sel_b=1, op=0, wr_acc=1.
  - SUB 00110: sel_a=10, sel_b=0, op=1, wr_acc=1.
  - SUBI 00111: sel_a=10, sel_b=1, op=1, wr_acc=1.
  - Undefined opcodes: NOP; no strobes, pc increments.
  - Non-HLT: pc ← pc+1 (mod 2^PC_W), → FETCH.
- Throughput: 3 cycles per instruction.
- operand holds IR operand during EXEC; pc_addr holds pc in all states.
- PC wrap: pc=2^PC_W−1 increments to 0 with no flag; execution continues.
- HALT: halted=1, all strobes 0. start=1 → FETCH with pc=0 and halted=0 the next cycle.
- start is ignored while busy.
- Outside EXEC (and rd_ram in DECODE): wr_acc, wr_ram, rd_ram = 0; sel_a=00, sel_b=0, op=0.

Optional Feature:
- Macro: BIP_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycle_count, 16 bits.
  - Counts clk cycles while busy=1; saturates at 0xFFFF.
  - Cleared by reset and when start launches execution; holds its value in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-EXEC of an ADD (wr_acc=1) → same cycle wr_acc=0, state IDLE, pc_addr=0; after release, stays IDLE until start.
- Program [LDI 5, ADDI 3, STO 0x010, HLT] →
  - cycles 3/6/9: wr_acc with sel_a=01; then sel_a=10, sel_b=1, op=0; then wr_ram=1 with operand=0x010.
  - halted=1 after the 4th EXEC; pc_addr=3.
- LD 0x020 then SUB 0x021 →
  - rd_ram=1 in each DECODE with operand 0x020 / 0x021.
  - SUB EXEC: sel_b=0, op=1, wr_acc=1.
- Undefined opcode 11111 at pc=0 → no strobes; next FETCH at pc_addr=1.
- Preload pc=0x7FF (NOP at that address) → next FETCH pc_addr=0x000.
- HALT then start=1 → FETCH at pc 0 next cycle, halted=0. With BIP_CYCLE_COUNT_EN, a 4-instruction run gives cycle_count=12 in HALT.

Source files
------------

// File: rtl/bip_control_unit_if.sv
// Program-memory and datapath control bus of the BIP control unit.
// master = control unit, slave = memories/datapath side.
interface bip_control_unit_if #(
  parameter int PC_W    = 11,
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc_addr;
  logic [PC_W-1:0]    operand;
  logic [1:0]         sel_a;
  logic               sel_b;
  logic               op;
  logic               wr_acc;
  logic               rd_ram;
  logic               wr_ram;

  modport master (
    input  instr,
    output pc_addr, operand, sel_a, sel_b,
    output op, wr_acc, rd_ram, wr_ram
  );

  modport slave (
    output instr,
    input  pc_addr, operand, sel_a, sel_b,
    input  op, wr_acc, rd_ram, wr_ram
  );
endinterface

// File: rtl/bip_control_unit.sv
// BIP multi-cycle control unit: FETCH/DECODE/EXEC sequencer and PC.
// Define BIP_CYCLE_COUNT_EN to add a saturating 16-bit busy-cycle counter.
module bip_control_unit #(
  parameter int PC_W    = 11,
  parameter int OPC_W   = 5,
  parameter int INSTR_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  bip_control_unit_if.master bus,
  output logic busy,
  output logic halted
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [15:0] cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);

  state_t               r_state;
  state_t               w_next;
  logic [PC_W-1:0]      r_pc;
  logic [PC_W-1:0]      w_pc_next;
  logic [INSTR_W-1:0]   r_ir;
  logic [OPC_W-1:0]     w_opc;
  logic [OPC_W-1:0]     w_dopc;
  logic                 w_arith;
  logic [1:0]           w_sel_a;
  logic                 w_sel_b;
  logic                 w_op;
  logic                 w_wr_acc;
  logic                 w_rd_ram;
  logic                 w_wr_ram;

  assign w_opc  = r_ir[INSTR_W-1:PC_W];
  assign w_dopc = bus.instr[INSTR_W-1:PC_W];
  assign w_arith = (w_opc == OP_ADD) ||
                   (w_opc == OP_ADDI) ||
                   (w_opc == OP_SUB) ||
                   (w_opc == OP_SUBI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      if (r_state == S_DECODE)
        r_ir <= bus.instr;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_pc_next = r_pc;
    w_sel_a   = 2'b00;
    w_sel_b   = 1'b0;
    w_op      = 1'b0;
    w_wr_acc  = 1'b0;
    w_rd_ram  = 1'b0;
    w_wr_ram  = 1'b0;
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_next    = S_FETCH;
          w_pc_next = '0;
        end
      end
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        // RAM read issued early so data lands in EXEC
        w_rd_ram = (w_dopc == OP_LD) ||
                   (w_dopc == OP_ADD) ||
                   (w_dopc == OP_SUB);
        w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next    = S_FETCH;
        w_pc_next = r_pc + PC_W'(1);
        unique case (1'b1)
          (w_opc == OP_HLT): begin
            w_next    = S_HALT;
            w_pc_next = r_pc;
          end
          (w_opc == OP_STO): w_wr_ram = 1'b1;
          (w_opc == OP_LD):  w_wr_acc = 1'b1;
          (w_opc == OP_LDI): begin
            w_sel_a  = 2'b01;
            w_wr_acc = 1'b1;
          end
          w_arith: begin
            w_sel_a  = 2'b10;
            w_sel_b  = w_opc[0];
            w_op     = w_opc[1];
            w_wr_acc = 1'b1;
          end
          default: ;
        endcase
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.pc_addr = r_pc;
  assign bus.operand = (r_state == S_DECODE) ?
                       bus.instr[PC_W-1:0] : r_ir[PC_W-1:0];
  assign bus.sel_a   = w_sel_a;
  assign bus.sel_b   = w_sel_b;
  assign bus.op      = w_op;
  assign bus.wr_acc  = w_wr_acc;
  assign bus.rd_ram  = w_rd_ram;
  assign bus.wr_ram  = w_wr_ram;

  assign busy   = (r_state == S_FETCH) ||
                  (r_state == S_DECODE) ||
                  (r_state == S_EXEC);
  assign halted = (r_state == S_HALT);

`ifdef BIP_CYCLE_COUNT_EN
  logic [15:0] r_cyc;
  logic        w_launch;

  assign w_launch = start &&
                    ((r_state == S_IDLE) || (r_state == S_HALT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cyc <= '0;
    else if (w_launch)
      r_cyc <= '0;
    else if (busy && (r_cyc != 16'hFFFF))
      r_cyc <= r_cyc + 16'd1;
  end

  assign cycle_count = r_cyc;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: opcode table, directed
// sequences and random programs against an instruction-level model.
module tb_bip_control_unit;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic halted;
`ifdef BIP_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [2048];

  bip_control_unit_if #(.PC_W(11), .INSTR_W(16)) bus ();

  bip_control_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .halted (halted)
`ifdef BIP_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  // registered program ROM
  always @(posedge clk) bus.instr <= mem[bus.pc_addr];

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       rd_ram;
    logic       wr_ram;
    logic       hlt;
  } ctrl_t;

  typedef struct {
    logic [4:0]  opc;
    logic [10:0] opd;
    ctrl_t       exp;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(logic [4:0] o, logic [10:0] d, ctrl_t e);
    vec_t v;
    v.opc = o;
    v.opd = d;
    v.exp = e;
    return v;
  endfunction

  // expected controls for an opcode; anything not listed is a NOP
  function automatic ctrl_t spec_ctrl(logic [4:0] o);
    ctrl_t c;
    c = '0;
    for (int i = 0; i < 10; i++)
      if (tbl[i].opc == o) c = tbl[i].exp;
    return c;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("launch_busy", busy, 1);
    chk("launch_halted", halted, 0);
    chk("launch_pc", bus.pc_addr, 0);
  endtask

  // checks one instruction from FETCH through to the following state
  task automatic run_one(input logic [10:0] pc, input bit rnd_start);
    logic [15:0] ins;
    ctrl_t       e;
    logic [10:0] nxt;
    ins = mem[pc];
    e   = spec_ctrl(ins[15:11]);
    nxt = pc + 11'd1;
    chk("fetch_busy", busy, 1);
    chk("fetch_pc", bus.pc_addr, pc);
    chk("fetch_strb", {bus.wr_acc, bus.rd_ram, bus.wr_ram}, 0);
    if (rnd_start) start = 1'($urandom_range(0, 1));
    tick();
    chk("dec_operand", bus.operand, ins[10:0]);
    chk("dec_rd_ram", bus.rd_ram, e.rd_ram);
    chk("dec_wr", {bus.wr_acc, bus.wr_ram, bus.sel_a}, 0);
    if (rnd_start) start = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    chk("exec_ctrl",
        {bus.sel_a, bus.sel_b, bus.op, bus.wr_acc, bus.rd_ram, bus.wr_ram},
        {e.sel_a, e.sel_b, e.op, e.wr_acc, 1'b0, e.wr_ram});
    chk("exec_operand", bus.operand, ins[10:0]);
    tick();
    if (e.hlt) begin
      chk("halt_flag", {busy, halted}, 2'b01);
      chk("halt_pc", bus.pc_addr, pc);
      chk("halt_strb", {bus.wr_acc, bus.rd_ram, bus.wr_ram}, 0);
    end else begin
      chk("next_busy", busy, 1);
      chk("next_pc", bus.pc_addr, nxt);
    end
  endtask

  initial begin
    logic [10:0] pc;
    int          n;
    logic [4:0]  o;

    tbl[0] = mk(5'b00000, 11'h000, '{2'b00, 0, 0, 0, 0, 0, 1});
    tbl[1] = mk(5'b00001, 11'h010, '{2'b00, 0, 0, 0, 0, 1, 0});
    tbl[2] = mk(5'b00010, 11'h020, '{2'b00, 0, 0, 1, 1, 0, 0});
    tbl[3] = mk(5'b00011, 11'h005, '{2'b01, 0, 0, 1, 0, 0, 0});
    tbl[4] = mk(5'b00100, 11'h7FF, '{2'b10, 0, 0, 1, 1, 0, 0});
    tbl[5] = mk(5'b00101, 11'h003, '{2'b10, 1, 0, 1, 0, 0, 0});
    tbl[6] = mk(5'b00110, 11'h021, '{2'b10, 0, 1, 1, 1, 0, 0});
    tbl[7] = mk(5'b00111, 11'h555, '{2'b10, 1, 1, 1, 0, 0, 0});
    tbl[8] = mk(5'b11111, 11'h2AA, '{2'b00, 0, 0, 0, 0, 0, 0});
    tbl[9] = mk(5'b01010, 11'h123, '{2'b00, 0, 0, 0, 0, 0, 0});

    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_busy_halted", {busy, halted}, 0);
    chk("rst_pc", bus.pc_addr, 0);
    chk("rst_outs",
        {bus.operand, bus.sel_a, bus.sel_b, bus.op,
         bus.wr_acc, bus.rd_ram, bus.wr_ram}, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_wait", {busy, halted}, 0);

    // opcode table: one instruction at pc 0, then HLT
    for (int i = 0; i < 10; i++) begin
      mem[0] = {tbl[i].opc, tbl[i].opd};
      mem[1] = 16'h0000;
      launch();
      run_one(11'd0, 1'b0);
      if (!tbl[i].exp.hlt) run_one(11'd1, 1'b0);
      chk("tbl_halted", halted, 1);
    end

    // LDI 5, ADDI 3, STO 0x010, HLT
    mem[0] = {5'b00011, 11'h005};
    mem[1] = {5'b00101, 11'h003};
    mem[2] = {5'b00001, 11'h010};
    mem[3] = 16'h0000;
    launch();
    for (int i = 0; i < 4; i++) run_one(11'(i), 1'b0);
    chk("prog1_pc", bus.pc_addr, 3);
`ifdef BIP_CYCLE_COUNT_EN
    chk("prog1_cycles", cycle_count, 12);
    repeat (2) tick();
    chk("halt_hold_cycles", cycle_count, 12);
`endif

    // LD 0x020, SUB 0x021, HLT
    mem[0] = {5'b00010, 11'h020};
    mem[1] = {5'b00110, 11'h021};
    mem[2] = 16'h0000;
    launch();
    for (int i = 0; i < 3; i++) run_one(11'(i), 1'b0);

    // asynchronous reset in the middle of an ADD execute
    mem[0] = {5'b00100, 11'h00F};
    launch();
    tick();
    tick();
    chk("pre_rst_wr_acc", bus.wr_acc, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_acc", bus.wr_acc, 0);
    chk("mid_rst_state", {busy, halted}, 0);
    chk("mid_rst_pc", bus.pc_addr, 0);
    reset = 1'b1;
    tick();
    repeat (4) begin
      tick();
      chk("post_rst_idle", {busy, halted, bus.wr_acc}, 0);
    end

    // random programs with start toggled while busy
    for (int p = 0; p < 25; p++) begin
      n = $urandom_range(2, 12);
      for (int i = 0; i < n - 1; i++) begin
        o = 5'($urandom_range(1, 31));
        mem[i] = {o, 11'($urandom)};
      end
      mem[n-1] = {5'b00000, 11'($urandom)};
      launch();
      pc = '0;
      for (int i = 0; i < n; i++) begin
        run_one(pc, 1'b1);
        pc = pc + 11'd1;
      end
`ifdef BIP_CYCLE_COUNT_EN
      chk("rnd_cycles", cycle_count, 3 * n);
`endif
    end

    // walk the full address space of NOPs to see the PC wrap
    for (int i = 0; i < 2048; i++) mem[i] = {5'b11111, 11'($urandom)};
    launch();
    for (int i = 0; i < 2048; i++) run_one(11'(i), 1'b0);
    chk("wrap_pc", bus.pc_addr, 0);
    chk("wrap_busy", busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
